// File: rtl/cond_pkg.sv
// Shared definitions for the execute-stage condition/flag unit.
// Holds condition-code and ALU-operation encodings, NZCV bit indices and
// the helper that classifies an ALU operation as arithmetic.
package cond_pkg;

  localparam int unsigned COND_W  = 4;
  localparam int unsigned ALU_W   = 4;
  localparam int unsigned FLAG_W  = 4;
  localparam int unsigned FLAGW_W = 2;

  // NZCV bit positions inside the 4-bit flag vector
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Condition field encodings
  localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
  localparam logic [COND_W-1:0] COND_NE = 4'b0001;
  localparam logic [COND_W-1:0] COND_CS = 4'b0010;
  localparam logic [COND_W-1:0] COND_CC = 4'b0011;
  localparam logic [COND_W-1:0] COND_MI = 4'b0100;
  localparam logic [COND_W-1:0] COND_PL = 4'b0101;
  localparam logic [COND_W-1:0] COND_VS = 4'b0110;
  localparam logic [COND_W-1:0] COND_VC = 4'b0111;
  localparam logic [COND_W-1:0] COND_HI = 4'b1000;
  localparam logic [COND_W-1:0] COND_LS = 4'b1001;
  localparam logic [COND_W-1:0] COND_GE = 4'b1010;
  localparam logic [COND_W-1:0] COND_LT = 4'b1011;
  localparam logic [COND_W-1:0] COND_GT = 4'b1100;
  localparam logic [COND_W-1:0] COND_LE = 4'b1101;
  localparam logic [COND_W-1:0] COND_AL = 4'b1110;

  // ALU operation encodings (data-processing opcode field)
  localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_EOR = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_RSB = 4'b0011;
  localparam logic [ALU_W-1:0] ALU_ADD = 4'b0100;
  localparam logic [ALU_W-1:0] ALU_ADC = 4'b0101;
  localparam logic [ALU_W-1:0] ALU_SBC = 4'b0110;
  localparam logic [ALU_W-1:0] ALU_RSC = 4'b0111;
  localparam logic [ALU_W-1:0] ALU_TST = 4'b1000;
  localparam logic [ALU_W-1:0] ALU_TEQ = 4'b1001;
  localparam logic [ALU_W-1:0] ALU_CMP = 4'b1010;
  localparam logic [ALU_W-1:0] ALU_CMN = 4'b1011;
  localparam logic [ALU_W-1:0] ALU_ORR = 4'b1100;
  localparam logic [ALU_W-1:0] ALU_MOV = 4'b1101;
  localparam logic [ALU_W-1:0] ALU_BIC = 4'b1110;
  localparam logic [ALU_W-1:0] ALU_MVN = 4'b1111;

  // True for ops whose C/V come from the adder
  function automatic logic is_arith(input logic [ALU_W-1:0] op);
    return op inside {ALU_SUB, ALU_RSB, ALU_ADD, ALU_ADC,
                      ALU_SBC, ALU_RSC, ALU_CMP, ALU_CMN};
  endfunction

endpackage

// File: rtl/cond_unit_if.sv
// Execute-stage bundle between decoder/ALU (master) and cond_unit (slave).
// Master drives instruction qualifiers, condition, ALU flags and write
// requests; slave returns gated enables, CondEx, stored flags and the
// annulled-instruction count.
interface cond_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic             Valid;
  logic             Stall;
  logic [3:0]       Cond;
  logic [3:0]       ALUControl;
  logic [3:0]       ALUFlags;
  logic             ShCarry;
  logic [1:0]       FlagW;
  logic             PCS;
  logic             RegW;
  logic             MemW;
  logic             NoWrite;
  logic             AnnulClr;
  logic             PCSrc;
  logic             RegWrite;
  logic             MemWrite;
  logic             CondEx;
  logic             C_out;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] AnnulCount;

  modport master (
    output Valid, Stall, Cond, ALUControl, ALUFlags, ShCarry, FlagW,
           PCS, RegW, MemW, NoWrite, AnnulClr,
    input  PCSrc, RegWrite, MemWrite, CondEx, C_out, Flags, AnnulCount
  );

  modport slave (
    input  Valid, Stall, Cond, ALUControl, ALUFlags, ShCarry, FlagW,
           PCS, RegW, MemW, NoWrite, AnnulClr,
    output PCSrc, RegWrite, MemWrite, CondEx, C_out, Flags, AnnulCount
  );
endinterface

// File: rtl/cond_check.sv
// Combinational ARM condition evaluator.
// Ports: Cond (4-bit condition field), Flags (stored NZCV) -> CondEx.
module cond_check
  import cond_pkg::*;
(
  input  logic [COND_W-1:0] Cond,
  input  logic [FLAG_W-1:0] Flags,
  output logic              CondEx
);

  logic n, z, c, v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  // AL and the 1111 encoding both fall through to always-pass
  always_comb begin
    CondEx = 1'b1;
    case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = (n == v);
      COND_LT: CondEx = (n != v);
      COND_GT: CondEx = ~z & (n == v);
      COND_LE: CondEx = z | (n != v);
      default: CondEx = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage condition and flag unit.
// Holds the NZCV register, evaluates the condition, gates PC/reg/mem write
// enables, feeds stored C back to the ALU, and counts annulled instructions
// (saturating).
// Ports: CLK, RESETn (async active-low), bus (cond_unit_if.slave).
// Build option: COND_SHIFT_CARRY_EN -- logical S-ops load C from ShCarry;
// otherwise C is preserved for logical ops.
module cond_unit
  import cond_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic        CLK,
  input  logic        RESETn,
  cond_unit_if.slave  bus
);

  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cond_ex;
  logic              issue;
  logic              go;
  logic              annul;

  cond_check u_check (
    .Cond   (bus.Cond),
    .Flags  (flags_q),
    .CondEx (cond_ex)
  );

  // Stalled or invalid slots neither write nor count
  assign issue = bus.Valid & ~bus.Stall;
  assign go    = issue & cond_ex;
  assign annul = issue & ~cond_ex;

  // Next flag value; V is never touched by logical ops
  always_comb begin
    flags_d = flags_q;
    if (go && bus.FlagW[1]) begin
      flags_d[FLAG_N] = bus.ALUFlags[FLAG_N];
      flags_d[FLAG_Z] = bus.ALUFlags[FLAG_Z];
    end
    if (go && bus.FlagW[0]) begin
      if (is_arith(bus.ALUControl)) begin
        flags_d[FLAG_C] = bus.ALUFlags[FLAG_C];
        flags_d[FLAG_V] = bus.ALUFlags[FLAG_V];
      end else begin
`ifdef COND_SHIFT_CARRY_EN
        flags_d[FLAG_C] = bus.ShCarry;
`else
        flags_d[FLAG_C] = flags_q[FLAG_C];
`endif
      end
    end
  end

`ifndef COND_SHIFT_CARRY_EN
  logic unused_sh_carry;
  assign unused_sh_carry = bus.ShCarry;
`endif

  // Saturating annul counter; clear takes priority over an annul event
  always_comb begin
    cnt_d = cnt_q;
    if (bus.AnnulClr) begin
      cnt_d = '0;
    end else if (annul && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.CondEx     = cond_ex;
  assign bus.PCSrc      = bus.PCS & go;
  assign bus.RegWrite   = bus.RegW & ~bus.NoWrite & go;
  assign bus.MemWrite   = bus.MemW & go;
  assign bus.C_out      = flags_q[FLAG_C];
  assign bus.Flags      = flags_q;
  assign bus.AnnulCount = cnt_q;

endmodule

// File: doc/cond_unit.md
# cond_unit

Execute-stage condition and flag unit sitting directly downstream of the ALU. It holds the architectural NZCV flag register and consumes the ALU's 4-bit flags. It evaluates the instruction's 4-bit condition field against the stored flags, gates the PC/register/memory write enables, and returns the stored carry to the ALU's carry input for ADC/SBC/RSC. It also keeps a saturating count of condition-failed (annulled) instructions for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of the annulled-instruction counter

Ports:
- CLK  in  1  clock, rising edge
- RESETn  in  1  asynchronous, active-low reset
- Valid  in  1  execute-stage instruction is valid
- Stall  in  1  execute stage held this cycle
- Cond  in  4  instruction condition field, bits [31:28]
- ALUControl  in  4  ALU operation code of the current instruction
- ALUFlags  in  4  {N,Z,C,V} from the ALU
- ShCarry  in  1  shifter carry-out (used only with COND_SHIFT_CARRY_EN)
- FlagW  in  2  [1] writes N,Z; [0] writes C,V
- PCS, RegW, MemW  in  1 each  decoder write requests
- NoWrite  in  1  compare-class op (CMP/CMN/TST/TEQ); suppresses RegWrite
- AnnulClr  in  1  synchronous clear of AnnulCount
- PCSrc, RegWrite, MemWrite  out  1 each  gated write enables
- CondEx  out  1  condition passed
- C_out  out  1  stored C flag, to the ALU carry input
- Flags  out  4  stored {N,Z,C,V}
- AnnulCount  out  CNT_W  saturating count of annulled instructions

## Operation
- CondEx is combinational from Cond and the stored Flags, using standard ARM semantics:
  - EQ/NE: Z
  - CS/CC: C
  - MI/PL: N
  - VS/VC: V
  - HI: C&~Z; LS: ~C|Z
  - GE: N==V; LT: N!=V
  - GT: ~Z&(N==V); LE: Z|(N!=V)
  - AL and 1111: 1
- Let go = Valid & ~Stall & CondEx.
  - PCSrc = PCS&go
  - RegWrite = RegW&~NoWrite&go
  - MemWrite = MemW&go
- Arithmetic set: ALUControl ∈ {0010,0011,0100,0101,0110,0111,1010,1011}. All other codes are logical.
- Flag update, at the clock edge when go:
  - FlagW[1]: N,Z ← ALUFlags N,Z.
  - FlagW[0] with an arithmetic op: C,V ← ALUFlags C,V.
  - FlagW[0] with a logical op: V is unchanged; C is handled as described under Configuration.
- Annul event = Valid & ~Stall & ~CondEx. On each event AnnulCount increments by 1, saturating at all-ones; it never wraps.
- If AnnulClr and an annul event occur in the same cycle, the clear wins and the count becomes 0.
- C_out = Flags[1], taken from the register, so the flags an instruction writes are seen by the next instruction.

## Timing
- Reset values: Flags=0000, C_out=0, AnnulCount=0. The gated outputs follow their inputs immediately; with Valid=0 they are all 0.
- Gated outputs and CondEx have zero-cycle (combinational) latency. Flags/C_out update one cycle after the qualifying edge.
- Stall=1:
  - PCSrc, RegWrite and MemWrite are forced to 0.
  - Flags and AnnulCount hold.
  - The instruction takes effect in the first cycle with Stall=0, so a stall never causes a double write.
- Valid=0 behaves like Stall, but AnnulClr still acts.
- An asynchronous RESETn assertion mid-instruction clears all state immediately. Outputs recover on the first edge after release.

## Configuration
- COND_SHIFT_CARRY_EN defined: for a logical op with FlagW[0], C ← ShCarry (ARM shifter-carry semantics).
- Undefined: for a logical op, C is preserved and ShCarry is ignored (the port remains, unused).
- V is preserved for logical ops in both builds.

## Structure
- Shared package cond_pkg holds:
  - condition-code constants (COND_EQ … COND_AL)
  - ALU operation encodings
  - the arithmetic-op membership function
  - flag bit indices (FLAG_N=3 … FLAG_V=0)
- One combinational sub-module, cond_check: inputs Cond and Flags, output CondEx. The flag register, gating and counter live in cond_unit.

## Test plan
- Reset: RESETn=0 → Flags=0000, C_out=0, AnnulCount=0. Then Cond=0000, Valid=1 → CondEx=0, MemWrite=0 with MemW=1.
- SUBS then EQ:
  - ALUControl=0010, ALUFlags=0110, FlagW=11, Cond=1110 → next cycle Flags=0110, C_out=1.
  - Then Cond=0000, RegW=1 → RegWrite=1.
- Annul: Flags=0000, Cond=0000, MemW=1, FlagW=11, ALUFlags=1111 → MemWrite=0, Flags stay 0000, AnnulCount 0→1.
- Logical S op: Flags=0011, ALUControl=0000, ALUFlags=1000, ShCarry=0, FlagW=11 → Flags=1011 without the macro, 1001 with it.
- Stall: Stall=1, Cond=1110, FlagW=11, ALUFlags=0100, RegW=1 → RegWrite=0, Flags unchanged. Stall=0 next cycle → RegWrite=1, Flags=0100 after the edge.
- Counter:
  - 65535 annuls → AnnulCount=FFFF; one more → stays FFFF.
  - AnnulClr together with an annul → 0.
  - LT with Flags N=1, V=0 → CondEx=1.
